// File: rtl/pim_row_engine.sv
// Row-parallel register array with a per-row ALU and a vector command sequencer.
// Commands are accepted in IDLE, executed one element per cycle, then answered.
module pim_row_engine #(
   parameter int COLS = 32,
   parameter int ROWS = 32,
   parameter int AW   = $clog2(ROWS)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            cmd_valid,
   output logic            cmd_ready,
   input  logic [2:0]      cmd_op,
   input  logic [AW-1:0]   cmd_dst,
   input  logic [AW-1:0]   cmd_src_a,
   input  logic [AW-1:0]   cmd_src_b,
   input  logic [AW-1:0]   cmd_cnt,
   input  logic            cmd_chain,
   input  logic            cmd_carry_in,
   input  logic [COLS-1:0] cmd_data,
   output logic            rsp_valid,
   input  logic            rsp_ready,
   output logic [COLS-1:0] rsp_data,
   output logic            rsp_carry,
   output logic            rsp_ovf,
   output logic [ROWS-1:0] overflow,
   output logic            sign_flag
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_WR   = 3'd1;
   localparam logic [2:0] OP_RD   = 3'd2;
   localparam logic [2:0] OP_ADD  = 3'd3;
   localparam logic [2:0] OP_AND  = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_OR   = 3'd6;
   localparam logic [2:0] OP_CLRF = 3'd7;

   typedef enum logic [1:0] {
      S_IDLE,
      S_EXEC,
      S_RESP
   } state_t;

   typedef struct packed {
      logic [2:0]      op;
      logic [AW-1:0]   dst;
      logic [AW-1:0]   src_a;
      logic [AW-1:0]   src_b;
      logic [AW-1:0]   cnt;
      logic            chain;
      logic            carry_in;
      logic [COLS-1:0] data;
   } cmd_t;

   state_t          state;
   state_t          state_nx;
   cmd_t            cmd_q;
   logic [COLS-1:0] mem [ROWS];
   logic [AW-1:0]   idx;
   logic            carry_q;
   logic            ovf_acc;

   logic            accept;
   logic            needs_exec;
   logic            exec_en;
   logic [AW-1:0]   row_d;
   logic [AW-1:0]   row_a;
   logic [AW-1:0]   row_b;
   logic [COLS-1:0] op_a;
   logic [COLS-1:0] op_b;
   logic            c_in;
   logic            c_out;
   logic [COLS-1:0] sum;
   logic            add_ovf;
   logic            last;
   logic            is_wr;
   logic            is_rd;
   logic            is_add;
   logic            is_and;
   logic            is_xor;
   logic            is_or;
   logic [COLS-1:0] res;
   logic            wr_en;
   logic            ovf_set;
   logic            cy;

   assign accept     = cmd_valid && cmd_ready;
   assign needs_exec = (cmd_op != OP_NOP) && (cmd_op != OP_CLRF);
   assign sign_flag  = mem[ROWS-1][COLS-1];

   assign is_wr  = (cmd_q.op == OP_WR);
   assign is_rd  = (cmd_q.op == OP_RD);
   assign is_add = (cmd_q.op == OP_ADD);
   assign is_and = (cmd_q.op == OP_AND);
   assign is_xor = (cmd_q.op == OP_XOR);
   assign is_or  = (cmd_q.op == OP_OR);

   // Element addressing wraps naturally at AW bits.
   assign row_d = cmd_q.dst + idx;
   assign row_a = cmd_q.src_a + idx;
   assign row_b = cmd_q.src_b + idx;
   assign op_a  = mem[row_a];
   assign op_b  = mem[row_b];
   assign last  = is_rd || is_wr || (idx == cmd_q.cnt);

   // Carry source: external carry unless chaining a later element.
   assign c_in = ((idx == '0) || !cmd_q.chain) ? cmd_q.carry_in
                                               : carry_q;
   assign {c_out, sum} = {1'b0, op_a} + {1'b0, op_b}
                       + {{COLS{1'b0}}, c_in};
   assign add_ovf = (op_a[COLS-1] == op_b[COLS-1])
                 && (sum[COLS-1] != op_a[COLS-1]);

   // Per-element ALU result and side effects.
   always_comb begin
      res     = '0;
      wr_en   = 1'b0;
      ovf_set = 1'b0;
      cy      = 1'b0;
      unique case (1'b1)
         is_wr: begin
            res   = cmd_q.data;
            wr_en = 1'b1;
         end
         is_rd: res = op_a;
         is_add: begin
            res     = sum;
            wr_en   = 1'b1;
            ovf_set = add_ovf;
            cy      = c_out;
         end
         is_and: begin
            res   = op_a & op_b;
            wr_en = 1'b1;
         end
         is_xor: begin
            res   = op_a ^ op_b;
            wr_en = 1'b1;
         end
         is_or: begin
            res   = op_a | op_b;
            wr_en = 1'b1;
         end
         default: ;
      endcase
   end

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= S_IDLE;
      else      state <= state_nx;
   end

   // FSM next-state logic.
   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: if (accept) state_nx = needs_exec ? S_EXEC : S_RESP;
         S_EXEC: if (last) state_nx = S_RESP;
         S_RESP: if (rsp_valid && rsp_ready) state_nx = S_IDLE;
         default: state_nx = S_IDLE;
      endcase
   end

   // FSM outputs.
   always_comb begin
      cmd_ready = (state == S_IDLE);
      exec_en   = (state == S_EXEC);
   end

   // Array, flags, command latch and element sequencing.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int r = 0; r < ROWS; r++) mem[r] <= '0;
         overflow  <= '0;
         cmd_q     <= '0;
         idx       <= '0;
         carry_q   <= 1'b0;
         ovf_acc   <= 1'b0;
         rsp_data  <= '0;
         rsp_carry <= 1'b0;
         rsp_ovf   <= 1'b0;
      end else begin
         if (accept) begin
            cmd_q <= '{op:       cmd_op,
                       dst:      cmd_dst,
                       src_a:    cmd_src_a,
                       src_b:    cmd_src_b,
                       cnt:      cmd_cnt,
                       chain:    cmd_chain,
                       carry_in: cmd_carry_in,
                       data:     cmd_data};
            idx       <= '0;
            carry_q   <= 1'b0;
            ovf_acc   <= 1'b0;
            rsp_data  <= '0;
            rsp_carry <= 1'b0;
            rsp_ovf   <= 1'b0;
            if (cmd_op == OP_CLRF) overflow <= '0;
         end
         if (exec_en) begin
            if (wr_en && (row_d != '0)) mem[row_d] <= res;
            if (ovf_set && (row_d != '0)) overflow[row_d] <= 1'b1;
            carry_q <= cy;
            ovf_acc <= ovf_acc | ovf_set;
            idx     <= idx + 1'b1;
            if (last) begin
               rsp_data  <= res;
               rsp_carry <= cy;
               rsp_ovf   <= ovf_acc | ovf_set;
            end
         end
      end
   end

   // Response valid rises one cycle into RESP, drops on handshake.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         rsp_valid <= 1'b0;
      else if ((state == S_RESP) && !rsp_valid)
         rsp_valid <= 1'b1;
      else if (rsp_valid && rsp_ready)
         rsp_valid <= 1'b0;
   end

endmodule

// File: doc/pim_row_engine.md
Name: pim_row_engine

Overview:
- Parametrised successor to the in-memory register cell array: a ROWS x COLS register array with a built-in per-row ALU (ADD/AND/XOR/OR) driven by a command sequencer.
- Adds multi-row vector commands, carry chaining across rows for multi-word arithmetic, sticky per-row overflow flags and a valid/ready command and response interface.
- Sits between the processor issue stage and the array; replaces the direct address-decoded bus control.

Parameters:
- COLS, 32, bits per row; ≥2.
- ROWS, 32, number of rows; power of two, ≥4.
- AW, $clog2(ROWS), row index width; derived, do not override.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  asynchronous active-low reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  engine accepts a command; high only in IDLE.
- cmd_op  in  3  0 NOP, 1 WRITE, 2 READ, 3 ADD, 4 AND, 5 XOR, 6 OR, 7 CLRF.
- cmd_dst  in  AW  first destination row.
- cmd_src_a  in  AW  first source-A row.
- cmd_src_b  in  AW  first source-B row.
- cmd_cnt  in  AW  vector length minus 1.
- cmd_chain  in  1  ADD only: carry-out of element i feeds element i+1.
- cmd_carry_in  in  1  carry into element 0 of ADD.
- cmd_data  in  COLS  WRITE data.
- rsp_valid  out  1  response available.
- rsp_ready  in  1  response consumed.
- rsp_data  out  COLS  READ value, or result of the last element.
- rsp_carry  out  1  carry-out of the last ADD element; 0 otherwise.
- rsp_ovf  out  1  OR of the signed overflow across all ADD elements.
- overflow  out  ROWS  sticky per-row signed-overflow flags.
- sign_flag  out  1  MSB of row ROWS-1; combinational from the array.

Behaviour:
- Reset (rst=0, async):
  - All rows, overflow, rsp_data, rsp_carry and rsp_ovf are cleared to 0; rsp_valid=0; FSM goes to IDLE.
  - cmd_ready=1 once rst deasserts.
  - Reset mid-command aborts the command with no response.
- Row 0 always reads 0. Writes to row 0 are silently dropped, but the result still appears on rsp_data and overflow[0] stays 0.
- FSM states: IDLE -> EXEC -> RESP -> IDLE.
  - IDLE: when cmd_valid && cmd_ready, latch all cmd_* fields, set element index i=0, go to EXEC.
  - NOP and CLRF do not enter EXEC. CLRF clears all overflow bits on the accept edge. Both go straight to RESP with rsp_data=0.
  - EXEC: one element per cycle for cmd_cnt+1 cycles; the last element moves to RESP.
  - Element i uses rows (dst+i), (a+i), (b+i), each mod ROWS (AW-bit wrap).
  - Element i sees the array as updated by elements 0..i-1 (read-after-write inside a vector is sequential).
  - READ and WRITE ignore cmd_cnt and take exactly one EXEC cycle.
  - RESP: rsp_valid=1, outputs held stable until rsp_ready=1. On that edge: rsp_valid=0 and go to IDLE. cmd_ready rises in the following cycle.
- Latency: accept at edge T; response valid after edge T+cmd_cnt+2 (or T+2 for READ/WRITE, T+1 for NOP/CLRF).
- WRITE: row[dst] <= cmd_data; rsp_data=cmd_data.
- READ: rsp_data = row[src_a].
- ADD arithmetic:
  - Computed at COLS+1 bits: {c_out, sum} = a + b + c_in.
  - c_in = cmd_carry_in for element 0. For later elements, c_in = previous c_out if cmd_chain=1, else cmd_carry_in.
  - Signed overflow = (a[MSB]==b[MSB]) && (sum[MSB]!=a[MSB]). It sets overflow[dst+i] (sticky, cleared only by CLRF or reset) and ORs into rsp_ovf.
- Logic ops (AND/XOR/OR): bitwise; rsp_carry=0, rsp_ovf=0; overflow flags unchanged.
- Inputs in RESP/EXEC: cmd_valid is ignored while cmd_ready=0. cmd_* may change freely after accept.

Test Plan:
- WRITE row 5 = 0x0000_0007, WRITE row 6 = 0x0000_0009, ADD dst=7 a=5 b=6 cin=0 -> READ row 7 gives 0x0000_0010; rsp_carry=0, rsp_ovf=0; response exactly 2 cycles after accept.
- Chained 64-bit add:
  - Setup: rows 2,3 = 0xFFFF_FFFF, 0x0000_0000; rows 4,5 = 0x0000_0001, 0x0000_0000.
  - Command: ADD dst=8 a=2 b=4 cnt=1 chain=1.
  - Expect: row 8 = 0, row 9 = 1, rsp_carry=0. With chain=0: row 9 = 0.
- Overflow: 0x7FFF_FFFF + 0x0000_0001 into row 10 -> overflow[10]=1, rsp_ovf=1, row 10 = 0x8000_0000; flag survives a later XOR into row 10; CLRF -> overflow=0.
- Wrap and row 0:
  - Setup: row 31 = 0x1234_5678.
  - Command: XOR dst=31 a=31 b=0 cnt=1 (ROWS=32).
  - Expect: element 1 hits row 0, whose write is dropped; READ row 0 = 0; READ row 31 = 0x1234_5678.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid and rsp_data stable, cmd_ready=0, cmd_valid ignored. Release -> one handshake, cmd_ready=1 next cycle.
- Reset mid-vector: assert rst in cycle 2 of an 8-element OR -> all rows 0, rsp_valid=0, overflow=0, no response after release.
